writeback_unit: RTL and testbench

Write-side driver for the processor's 16×32 register file. It accepts completed results from the execute stage (ALU/call) and the memory stage (load/store) over valid/ready handshakes. It arbitrates them onto the register file's single write port and presents registered `wr`/`drAddr`/`writeData`. A one-entry hold register absorbs same-cycle collisions, so neither producer's result is lost.

---
 rtl/writeback_unit.sv | 100 ++++++++++
 tb/tb_writeback_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Register-file write-port driver: arbitrates execute-stage and memory-stage
// results onto one registered write port, with a one-entry hold for collisions.
module writeback_unit #(
   parameter logic [3:0]  LINK_REG    = 4'd15,
   parameter logic [31:0] LINK_OFFSET = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [3:0]  alu_rd,
   input  logic [31:0] alu_result,
   input  logic        alu_isCall,
   input  logic [31:0] alu_pc,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [3:0]  mem_rd,
   input  logic [31:0] mem_data,
   input  logic        mem_isLd,
   output logic        wr,
   output logic [3:0]  drAddr,
   output logic [31:0] writeData,
   output logic        busy,
   output logic [15:0] wb_count
);

   logic        holdValid;
   logic [3:0]  holdAddr;
   logic [31:0] holdData;

   logic        aluFire_p0;
   logic        memWrite_p0;
   logic [3:0]  aluAddr_p0;
   logic [31:0] aluData_p0;
   logic        issueVld_p0;
   logic [3:0]  issueAddr_p0;
   logic [31:0] issueData_p0;
   logic        holdLoad_p0;

   // Link address wraps modulo 2^32.
   function automatic logic [31:0] linkAddr(input logic [31:0] pc);
      return pc + LINK_OFFSET;
   endfunction

   assign alu_ready   = !holdValid && !rst;
   assign mem_ready   = !holdValid && !rst;
   assign aluFire_p0  = alu_valid && alu_ready;
   assign memWrite_p0 = mem_valid && mem_ready && mem_isLd;
   assign aluAddr_p0  = alu_isCall ? LINK_REG : alu_rd;
   assign aluData_p0  = alu_isCall ? linkAddr(alu_pc) : alu_result;

   // A load is the older result, so it wins a collision and the ALU waits in hold.
   always_comb begin
      issueVld_p0  = 1'b0;
      issueAddr_p0 = holdAddr;
      issueData_p0 = holdData;
      holdLoad_p0  = 1'b0;
      if (holdValid) begin
         issueVld_p0 = 1'b1;
      end else if (memWrite_p0) begin
         issueVld_p0  = 1'b1;
         issueAddr_p0 = mem_rd;
         issueData_p0 = mem_data;
         holdLoad_p0  = aluFire_p0;
      end else if (aluFire_p0) begin
         issueVld_p0  = 1'b1;
         issueAddr_p0 = aluAddr_p0;
         issueData_p0 = aluData_p0;
      end
   end

   // ---- stage p0 -> write port register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         wr        <= 1'b0;
         drAddr    <= 4'd0;
         writeData <= 32'd0;
         wb_count  <= 16'd0;
         holdValid <= 1'b0;
      end else begin
         wr        <= issueVld_p0;
         holdValid <= holdLoad_p0;
         if (issueVld_p0) begin
            drAddr    <= issueAddr_p0;
            writeData <= issueData_p0;
            wb_count  <= wb_count + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (holdLoad_p0) begin
         holdAddr <= aluAddr_p0;
         holdData <= aluData_p0;
      end
   end

   assign busy = holdValid || wr;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected writes are queued as transfers
// are accepted and compared in order whenever the unit asserts wr.
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready, alu_isCall, mem_valid, mem_ready, mem_isLd;
   logic [3:0]  alu_rd, mem_rd, drAddr;
   logic [31:0] alu_result, alu_pc, mem_data, writeData;
   logic        wr, busy;
   logic [15:0] wb_count;

   typedef struct packed {
      logic [3:0]  a;
      logic [31:0] d;
   } wb_t;

   wb_t         sb[$];
   logic [15:0] expCount;
   int          vectors = 0;
   int          miscompares = 0;

   writeback_unit dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
      .alu_result(alu_result), .alu_isCall(alu_isCall), .alu_pc(alu_pc),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
      .mem_data(mem_data), .mem_isLd(mem_isLd),
      .wr(wr), .drAddr(drAddr), .writeData(writeData),
      .busy(busy), .wb_count(wb_count)
   );

   always #5 clk = ~clk;

   // Output monitor: every issued write must match the oldest expectation.
   always @(negedge clk) begin
      if (wr === 1'b1) begin
         wb_t e;
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL spurious_write: got addr=%0d data=%h, required no write", drAddr, writeData);
         end else begin
            e = sb.pop_front();
            if (drAddr !== e.a || writeData !== e.d) begin
               miscompares++;
               $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                        drAddr, writeData, e.a, e.d);
            end
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      alu_valid = 1'b0; alu_isCall = 1'b0; alu_rd = 4'd0; alu_result = 32'd0; alu_pc = 32'd0;
      mem_valid = 1'b0; mem_isLd = 1'b0; mem_rd = 4'd0; mem_data = 32'd0;
   endtask

   task automatic push(input logic [3:0] a, input logic [31:0] d);
      sb.push_back('{a: a, d: d});
      expCount = expCount + 16'd1;
   endtask

   task automatic test_reset;
      idle();
      rst = 1'b1;
      step(); step();
      vectors++;
      if (wr !== 1'b0 || drAddr !== 4'd0 || writeData !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_port: got wr=%b addr=%0d data=%h, required 0/0/0", wr, drAddr, writeData);
      end
      vectors++;
      if (wb_count !== 16'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: got count=%0d busy=%b, required 0/0", wb_count, busy);
      end
      vectors++;
      if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready: got alu_ready=%b mem_ready=%b, required 0/0", alu_ready, mem_ready);
      end
      rst = 1'b0;
      sb.delete();
      expCount = 16'd0;
      #1;
      vectors++;
      if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_after_reset: got alu_ready=%b mem_ready=%b, required 1/1", alu_ready, mem_ready);
      end
   endtask

   task automatic test_alu_only;
      alu_valid = 1'b1; alu_rd = 4'd3; alu_result = 32'hDEADBEEF;
      push(4'd3, 32'hDEADBEEF);
      step();
      idle();
      vectors++;
      if (wr !== 1'b1 || drAddr !== 4'd3 || writeData !== 32'hDEADBEEF || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL alu_only: got wr=%b addr=%0d data=%h busy=%b, required 1/3/deadbeef/1",
                  wr, drAddr, writeData, busy);
      end
      vectors++;
      if (wb_count !== expCount) begin
         miscompares++;
         $display("FAIL alu_count: got %0d, required %0d", wb_count, expCount);
      end
      step();
      vectors++;
      if (wr !== 1'b0 || busy !== 1'b0 || drAddr !== 4'd3 || writeData !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL alu_idle: got wr=%b busy=%b addr=%0d data=%h, required 0/0/3/deadbeef",
                  wr, busy, drAddr, writeData);
      end
   endtask

   task automatic test_collision;
      mem_valid = 1'b1; mem_isLd = 1'b1; mem_rd = 4'd4; mem_data = 32'h11;
      alu_valid = 1'b1; alu_rd = 4'd4; alu_result = 32'h22;
      push(4'd4, 32'h11);
      push(4'd4, 32'h22);
      step();
      idle();
      // A new ALU request while the hold is full must wait.
      alu_valid = 1'b1; alu_rd = 4'd5; alu_result = 32'h33;
      vectors++;
      if (wr !== 1'b1 || drAddr !== 4'd4 || writeData !== 32'h11) begin
         miscompares++;
         $display("FAIL collision_first: got wr=%b addr=%0d data=%h, required 1/4/11", wr, drAddr, writeData);
      end
      vectors++;
      if (alu_ready !== 1'b0 || mem_ready !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL collision_ready: got alu_ready=%b mem_ready=%b busy=%b, required 0/0/1",
                  alu_ready, mem_ready, busy);
      end
      step();
      vectors++;
      if (wr !== 1'b1 || drAddr !== 4'd4 || writeData !== 32'h22) begin
         miscompares++;
         $display("FAIL collision_second: got wr=%b addr=%0d data=%h, required 1/4/22", wr, drAddr, writeData);
      end
      vectors++;
      if (alu_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL collision_release: got alu_ready=%b, required 1", alu_ready);
      end
      push(4'd5, 32'h33);
      step();
      idle();
      vectors++;
      if (wr !== 1'b1 || drAddr !== 4'd5 || writeData !== 32'h33) begin
         miscompares++;
         $display("FAIL stalled_alu: got wr=%b addr=%0d data=%h, required 1/5/33", wr, drAddr, writeData);
      end
      step();
      vectors++;
      if (wb_count !== expCount || sb.size() != 0) begin
         miscompares++;
         $display("FAIL collision_count: got count=%0d pending=%0d, required %0d/0", wb_count, sb.size(), expCount);
      end
   endtask

   task automatic test_back_to_back;
      alu_valid = 1'b1; alu_isCall = 1'b1; alu_pc = 32'h100; alu_rd = 4'd7; alu_result = 32'h999;
      push(4'd15, 32'h104);
      step();
      alu_pc = 32'hFFFF_FFFE; alu_rd = 4'd8;
      push(4'd15, 32'h2);
      vectors++;
      if (wr !== 1'b1 || drAddr !== 4'd15 || writeData !== 32'h104) begin
         miscompares++;
         $display("FAIL call_link: got wr=%b addr=%0d data=%h, required 1/15/104", wr, drAddr, writeData);
      end
      step();
      idle();
      vectors++;
      if (wr !== 1'b1 || drAddr !== 4'd15 || writeData !== 32'h2) begin
         miscompares++;
         $display("FAIL call_wrap: got wr=%b addr=%0d data=%h, required 1/15/2", wr, drAddr, writeData);
      end
      step();
      vectors++;
      if (wr !== 1'b0 || wb_count !== expCount) begin
         miscompares++;
         $display("FAIL call_count: got wr=%b count=%0d, required 0/%0d", wr, wb_count, expCount);
      end
   endtask

   task automatic test_store_alu;
      mem_valid = 1'b1; mem_isLd = 1'b0; mem_rd = 4'd9; mem_data = 32'hBAD;
      alu_valid = 1'b1; alu_rd = 4'd2; alu_result = 32'h55;
      push(4'd2, 32'h55);
      step();
      idle();
      vectors++;
      if (wr !== 1'b1 || drAddr !== 4'd2 || writeData !== 32'h55 || alu_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL store_alu: got wr=%b addr=%0d data=%h ready=%b, required 1/2/55/1",
                  wr, drAddr, writeData, alu_ready);
      end
      step();
      vectors++;
      if (wr !== 1'b0 || busy !== 1'b0 || wb_count !== expCount) begin
         miscompares++;
         $display("FAIL store_after: got wr=%b busy=%b count=%0d, required 0/0/%0d", wr, busy, wb_count, expCount);
      end
      // Load into r0 must be written.
      mem_valid = 1'b1; mem_isLd = 1'b1; mem_rd = 4'd0; mem_data = 32'hA5A5_0F0F;
      push(4'd0, 32'hA5A5_0F0F);
      step();
      idle();
      vectors++;
      if (wr !== 1'b1 || drAddr !== 4'd0 || writeData !== 32'hA5A5_0F0F) begin
         miscompares++;
         $display("FAIL load_r0: got wr=%b addr=%0d data=%h, required 1/0/a5a50f0f", wr, drAddr, writeData);
      end
      step();
   endtask

   task automatic test_reset_mid;
      mem_valid = 1'b1; mem_isLd = 1'b1; mem_rd = 4'd6; mem_data = 32'h77;
      alu_valid = 1'b1; alu_rd = 4'd6; alu_result = 32'h88;
      push(4'd6, 32'h77);
      step();
      idle();
      rst = 1'b1;
      step();
      vectors++;
      if (wr !== 1'b0 || drAddr !== 4'd0 || writeData !== 32'd0 || wb_count !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_mid: got wr=%b addr=%0d data=%h count=%0d, required 0/0/0/0",
                  wr, drAddr, writeData, wb_count);
      end
      vectors++;
      if (busy !== 1'b0 || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_ctl: got busy=%b alu_ready=%b mem_ready=%b, required 0/0/0",
                  busy, alu_ready, mem_ready);
      end
      expCount = 16'd0;
      rst = 1'b0;
      #1;
      vectors++;
      if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_ready: got %b/%b, required 1/1", alu_ready, mem_ready);
      end
      step(); step();
      vectors++;
      if (wr !== 1'b0 || wb_count !== 16'd0 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL held_discarded: got wr=%b count=%0d pending=%0d, required 0/0/0", wr, wb_count, sb.size());
      end
   endtask

   task automatic test_wrap;
      logic [31:0] val;
      for (int i = 0; i < 65536; i++) begin
         val = $urandom;
         alu_valid = 1'b1; alu_rd = i[3:0]; alu_result = val;
         if (alu_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL wrap_ready: cycle %0d got alu_ready=%b, required 1", i, alu_ready);
         end
         push(i[3:0], val);
         step();
         if (i == 65534) begin
            vectors++;
            if (wb_count !== 16'hFFFF) begin
               miscompares++;
               $display("FAIL wrap_max: got %h, required ffff", wb_count);
            end
         end
      end
      idle();
      step(); step();
      vectors++;
      if (wb_count !== 16'd0 || wb_count !== expCount || sb.size() != 0) begin
         miscompares++;
         $display("FAIL wrap_zero: got count=%h pending=%0d, required 0/0", wb_count, sb.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      expCount = 16'd0;
      idle();
      test_reset();
      test_alu_only();
      test_collision();
      test_back_to_back();
      test_store_alu();
      test_reset_mid();
      test_reset();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
